mac_accumulator: RTL and testbench



---
 rtl/mac_accumulator.sv | 117 +++++++++++
 tb/tb_mac_accumulator.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_accumulator.sv
// mac_accumulator: registered operand pairs through a multiplier into a vector dot-product accumulator.
// The multiplier is either synthesizer-inferred or a carry-save reduction of partial products.
module multiplier #(
   parameter int parallelism = 8,
   parameter int ARCH_TYPE   = 0
) (
   input  logic [parallelism-1:0]   a,
   input  logic [parallelism-1:0]   b,
   output logic [2*parallelism-1:0] p
);
   localparam int W = 2*parallelism;
   generate
      if (ARCH_TYPE == 1) begin : g_csa
         logic [W-1:0] s, c, pp, t;
         // 3:2 compress each partial product into the sum/carry pair; one carry-propagate add at the end
         always_comb begin
            s = '0;
            c = '0;
            pp = '0;
            t = '0;
            for (int i = 0; i < parallelism; i++) begin
               pp = b[i] ? (W'(a) << i) : '0;
               t = s ^ c ^ pp;
               c = ((s & c) | (s & pp) | (c & pp)) << 1;
               s = t;
            end
            p = s + c;
         end
      end else begin : g_syn
         assign p = W'(a) * W'(b);
      end
   endgenerate
endmodule

module mac_accumulator #(
   parameter int parallelism = 8,
   parameter int MULT_ARCH   = 0,
   parameter int ACC_WIDTH   = 2*parallelism+8,
   parameter int CNT_WIDTH   = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [parallelism-1:0] in_a,
   input  logic [parallelism-1:0] in_b,
   input  logic                   in_last,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ACC_WIDTH-1:0]   out_acc,
   output logic [CNT_WIDTH-1:0]   out_count,
   output logic                   out_ovf
);
   logic                     v1, last1, out_free, adv;
   logic [parallelism-1:0]   a1, b1;
   logic [2*parallelism-1:0] product;
   logic [ACC_WIDTH-1:0]     acc;
   logic [CNT_WIDTH-1:0]     cnt;
   logic                     ovf;
   logic [ACC_WIDTH:0]       sum;

   multiplier #(.parallelism(parallelism), .ARCH_TYPE(MULT_ARCH)) u_mult (
      .a(a1),
      .b(b1),
      .p(product)
   );

   assign out_free = !out_valid || out_ready;
   // only a vector-closing pair needs the output register, so only it can stall
   assign adv      = v1 && (!last1 || out_free);
   assign in_ready = !v1 || adv;
   assign sum      = {1'b0, acc} + (ACC_WIDTH+1)'(product);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1    <= 1'b0;
         last1 <= 1'b0;
         a1    <= '0;
         b1    <= '0;
      end else if (in_valid && in_ready) begin
         v1    <= 1'b1;
         last1 <= in_last;
         a1    <= in_a;
         b1    <= in_b;
      end else if (adv) begin
         v1    <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end else if (adv) begin
         acc <= last1 ? '0 : sum[ACC_WIDTH-1:0];
         cnt <= last1 ? '0 : cnt + 1'b1;
         ovf <= last1 ? 1'b0 : ovf | sum[ACC_WIDTH];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_acc   <= '0;
         out_count <= '0;
         out_ovf   <= 1'b0;
      end else if (adv && last1) begin
         out_valid <= 1'b1;
         out_acc   <= sum[ACC_WIDTH-1:0];
         out_count <= cnt + 1'b1;
         out_ovf   <= ovf | sum[ACC_WIDTH];
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_mac_accumulator.sv
// tb_mac_accumulator: three shared-stimulus instances (arch 0/1 at 24-bit, arch 1 at 16-bit) checked against a dot-product model.
module tb_mac_accumulator;
   localparam int P = 8;
   logic clk = 0, rst_n = 0;
   always #5 clk = ~clk;
   logic           in_valid = 0, in_last = 0, out_ready = 0;
   logic [P-1:0]   in_a = 0, in_b = 0;
   logic [2:0]     in_ready, out_valid, out_ovf;
   logic [23:0]    acc0, acc1;
   logic [15:0]    acc2;
   logic [7:0]     cnt0, cnt1, cnt2;
   int checks = 0, errors = 0;
   typedef struct {longint sum; int n;} res_t;
   res_t   exp_q[$];
   longint part_sum = 0;
   int     part_n = 0;
   bit     rand_ready = 0;

   mac_accumulator #(.parallelism(P), .MULT_ARCH(0)) d0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]), .in_a(in_a), .in_b(in_b),
      .in_last(in_last), .out_valid(out_valid[0]), .out_ready(out_ready), .out_acc(acc0), .out_count(cnt0), .out_ovf(out_ovf[0]));
   mac_accumulator #(.parallelism(P), .MULT_ARCH(1)) d1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]), .in_a(in_a), .in_b(in_b),
      .in_last(in_last), .out_valid(out_valid[1]), .out_ready(out_ready), .out_acc(acc1), .out_count(cnt1), .out_ovf(out_ovf[1]));
   mac_accumulator #(.parallelism(P), .MULT_ARCH(1), .ACC_WIDTH(16)) d2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[2]), .in_a(in_a), .in_b(in_b),
      .in_last(in_last), .out_valid(out_valid[2]), .out_ready(out_ready), .out_acc(acc2), .out_count(cnt2), .out_ovf(out_ovf[2]));

   // every result handshake is scored against the next expected dot product
   always @(negedge clk) begin : mon
      res_t e;
      if (rst_n && out_valid[0] && out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output acc=%0d count=%0d", acc0, cnt0);
         end else begin
            e = exp_q.pop_front();
            if ({acc0, cnt0, out_ovf[0]} !== {24'(e.sum), 8'(e.n), (e.sum >> 24) != 0}) begin
               errors++;
               $display("FAIL result_arch0 got acc=%0d cnt=%0d ovf=%0d want sum=%0d n=%0d", acc0, cnt0, out_ovf[0], e.sum, e.n);
            end
            checks++;
            if ({out_valid[1], acc1, cnt1, out_ovf[1]} !== {1'b1, 24'(e.sum), 8'(e.n), (e.sum >> 24) != 0}) begin
               errors++;
               $display("FAIL result_arch1 got v=%0d acc=%0d cnt=%0d ovf=%0d want sum=%0d n=%0d", out_valid[1], acc1, cnt1, out_ovf[1], e.sum, e.n);
            end
            checks++;
            if ({out_valid[2], acc2, cnt2, out_ovf[2]} !== {1'b1, 16'(e.sum), 8'(e.n), (e.sum >> 16) != 0}) begin
               errors++;
               $display("FAIL result_acc16 got v=%0d acc=%0d cnt=%0d ovf=%0d want sum=%0d n=%0d", out_valid[2], acc2, cnt2, out_ovf[2], e.sum, e.n);
            end
         end
      end
   end

   task automatic send(input logic [P-1:0] a, input logic [P-1:0] b, input logic last);
      bit ok = 0;
      int n = 0;
      in_valid = 1; in_a = a; in_b = b; in_last = last;
      do begin
         if (rand_ready) out_ready = ($urandom_range(0, 9) < 7);
         #1 ok = in_ready[0];
         @(posedge clk); #1;
         n++;
      end while (!ok && n < 200);
      if (!ok) begin
         checks++; errors++;
         $display("FAIL send_timeout in_ready=0 want 1 within 200 cycles");
      end else begin
         part_sum += longint'(a) * longint'(b);
         part_n++;
         if (last) begin
            exp_q.push_back('{part_sum, part_n});
            part_sum = 0;
            part_n = 0;
         end
      end
   endtask

   task automatic drain();
      int n = 0;
      in_valid = 0; in_last = 0; out_ready = 1; rand_ready = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      repeat (2) @(posedge clk);
      #1 checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d want 0", exp_q.size());
      end
   endtask

   task automatic test_reset();
      #2 checks++;
      if ({in_ready[0], out_valid, acc0, cnt0, out_ovf} !== {1'b1, 3'b0, 24'd0, 8'd0, 3'b0}) begin
         errors++;
         $display("FAIL reset_values in_ready=%0d valid=%0d acc=%0d cnt=%0d ovf=%0d", in_ready[0], out_valid, acc0, cnt0, out_ovf);
      end
      @(posedge clk); #1 rst_n = 1;
      out_ready = 0;
      send(9, 9, 1);
      send(3, 3, 0);
      send(4, 4, 0);
      #3 rst_n = 0;
      exp_q.delete(); part_sum = 0; part_n = 0;
      #1 checks++;
      if ({in_ready[0], out_valid, acc0, acc2, cnt0, out_ovf} !== {1'b1, 3'b0, 24'd0, 16'd0, 8'd0, 3'b0}) begin
         errors++;
         $display("FAIL midstream_reset in_ready=%0d valid=%0d acc=%0d cnt=%0d want 1/0/0/0", in_ready[0], out_valid, acc0, cnt0);
      end
      @(posedge clk); #1 rst_n = 1; out_ready = 1; in_valid = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1 checks++;
         if (out_valid !== 3'b0) begin
            errors++;
            $display("FAIL no_output_after_reset cycle=%0d valid=%0d want 0", i, out_valid);
         end
      end
   endtask

   task automatic test_basic();
      out_ready = 1;
      send(3, 4, 0);
      send(5, 6, 0);
      send(7, 8, 1);
      in_valid = 0;
      checks++;
      if (out_valid[0] !== 1'b0) begin
         errors++;
         $display("FAIL basic_early_valid valid=%0d want 0", out_valid[0]);
      end
      @(posedge clk); #1 checks++;
      if ({out_valid[0], acc0, cnt0, out_ovf[0]} !== {1'b1, 24'd98, 8'd3, 1'b0}) begin
         errors++;
         $display("FAIL basic_dot valid=%0d acc=%0d cnt=%0d ovf=%0d want 1/98/3/0", out_valid[0], acc0, cnt0, out_ovf[0]);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      out_ready = 1;
      send(255, 255, 1);
      send(1, 1, 1);
      in_valid = 0;
      checks++;
      if ({out_valid[0], acc0, cnt0} !== {1'b1, 24'd65025, 8'd1}) begin
         errors++;
         $display("FAIL b2b_first valid=%0d acc=%0d cnt=%0d want 1/65025/1", out_valid[0], acc0, cnt0);
      end
      @(posedge clk); #1 checks++;
      if ({out_valid[0], acc0, cnt0} !== {1'b1, 24'd1, 8'd1}) begin
         errors++;
         $display("FAIL b2b_second valid=%0d acc=%0d cnt=%0d want 1/1/1", out_valid[0], acc0, cnt0);
      end
      drain();
   endtask

   task automatic test_backpressure();
      out_ready = 0;
      send(1, 2, 1);
      in_valid = 0;
      @(posedge clk); #1 checks++;
      if ({out_valid[0], acc0} !== {1'b1, 24'd2}) begin
         errors++;
         $display("FAIL bp_held valid=%0d acc=%0d want 1/2", out_valid[0], acc0);
      end
      send(2, 2, 0);
      send(2, 2, 0);
      send(2, 2, 1);
      in_valid = 0;
      for (int i = 0; i < 3; i++) begin
         #1 checks++;
         if ({in_ready[0], out_valid[0], acc0, cnt0} !== {1'b0, 1'b1, 24'd2, 8'd1}) begin
            errors++;
            $display("FAIL bp_stall cycle=%0d in_ready=%0d valid=%0d acc=%0d want 0/1/2", i, in_ready[0], out_valid[0], acc0);
         end
         @(posedge clk); #1;
      end
      out_ready = 1;
      #1 checks++;
      if (in_ready[0] !== 1'b1) begin
         errors++;
         $display("FAIL bp_release in_ready=%0d want 1", in_ready[0]);
      end
      @(posedge clk); #1 checks++;
      if ({out_valid[0], acc0, cnt0} !== {1'b1, 24'd12, 8'd3}) begin
         errors++;
         $display("FAIL bp_next valid=%0d acc=%0d cnt=%0d want 1/12/3", out_valid[0], acc0, cnt0);
      end
      drain();
   endtask

   task automatic test_overflow();
      out_ready = 1;
      send(255, 255, 0);
      send(255, 255, 1);
      in_valid = 0;
      @(posedge clk); #1 checks++;
      if ({acc2, out_ovf[2], acc0, out_ovf[0]} !== {16'd64514, 1'b1, 24'd130050, 1'b0}) begin
         errors++;
         $display("FAIL ovf_wrap acc16=%0d ovf16=%0d acc24=%0d ovf24=%0d want 64514/1/130050/0", acc2, out_ovf[2], acc0, out_ovf[0]);
      end
      send(1, 1, 1);
      in_valid = 0;
      @(posedge clk); #1 checks++;
      if ({acc2, out_ovf[2]} !== {16'd1, 1'b0}) begin
         errors++;
         $display("FAIL ovf_clear acc16=%0d ovf16=%0d want 1/0", acc2, out_ovf[2]);
      end
      drain();
   endtask

   task automatic test_count_wrap();
      out_ready = 1;
      for (int i = 0; i < 256; i++) send(1, 1, i == 255);
      in_valid = 0;
      @(posedge clk); #1 checks++;
      if ({out_valid[0], acc0, cnt0} !== {1'b1, 24'd256, 8'd0}) begin
         errors++;
         $display("FAIL count_wrap valid=%0d acc=%0d cnt=%0d want 1/256/0", out_valid[0], acc0, cnt0);
      end
      drain();
   endtask

   task automatic test_random();
      rand_ready = 1;
      for (int i = 0; i < 1000; i++)
         send(P'($urandom), P'($urandom), $urandom_range(0, 7) == 0);
      send(P'($urandom), P'($urandom), 1);
      drain();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_backpressure();
      test_overflow();
      test_count_wrap();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
